cdb_arbiter: RTL

- Arbitrates one Common Data Bus (CDB) between NUM_FU functional-unit completion ports. Requesters are the ALUs, the branch unit and the last stage of the pipelined mult.
- Grants one requester per cycle, round-robin. The grant is returned combinationally as that FU's CDB_valid (advance/stall).
- The winning result is registered onto the CDB for RS wakeup, map-table update and ROB completion.
- Results younger than a branch rollback are squashed before they can win.

---
 rtl/cdb_arbiter_pkg.sv | 13 +
 rtl/cdb_arbiter_rr_arbiter.sv | 39 +++
 rtl/cdb_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter slice: default sizing and the zero physical register.
// The optional mult-priority override is selected by the MULT_PRIO_EN macro in cdb_arbiter.
package cdb_arbiter_pkg;

  localparam int unsigned DEF_NUM_FU  = 4;
  localparam int unsigned DEF_NUM_ROB = 32;
  localparam int unsigned DEF_NUM_PR  = 64;
  localparam int unsigned VALUE_W     = 64;

  // Architectural zero maps here; such results still arbitrate so the ROB sees completion.
  localparam int unsigned ZERO_PR     = 0;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin arbiter: rotate requests by ptr, priority-encode the lowest, rotate the index back.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] winner
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW-1:0]  k;
  logic           found;
  logic [PW:0]    sum;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    k     = '0;
    found = 1'b0;
    // Scan downward so the lowest rotated position is the last assignment.
    for (int unsigned j = N; j > 0; j--) begin
      if (rot[j-1]) begin
        k     = PW'(j - 1);
        found = 1'b1;
      end
    end
    sum = {1'b0, k} + {1'b0, ptr};
    if (sum >= (PW+1)'(N))
      sum = sum - (PW+1)'(N);
    winner = sum[PW-1:0];
    gnt    = '0;
    if (found)
      gnt[winner] = 1'b1;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: squash filter, round-robin grant, registered CDB broadcast.
// Define MULT_PRIO_EN to let the mult (highest FU index) win whenever it is eligible.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_FU  = DEF_NUM_FU,
  parameter  int unsigned NUM_ROB = DEF_NUM_ROB,
  parameter  int unsigned NUM_PR  = DEF_NUM_PR,
  localparam int unsigned RW      = $clog2(NUM_ROB),
  localparam int unsigned TW      = $clog2(NUM_PR),
  localparam int unsigned PW      = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_FU-1:0]         fu_done,
  input  logic [NUM_FU*TW-1:0]      fu_T_idx,
  input  logic [NUM_FU*RW-1:0]      fu_ROB_idx,
  input  logic [NUM_FU*VALUE_W-1:0] fu_result,
  input  logic                      ROB_rollback_en,
  input  logic [RW-1:0]             ROB_rollback_idx,
  input  logic [RW-1:0]             ROB_tail_idx,
  output logic [NUM_FU-1:0]         fu_grant,
  output logic                      CDB_valid,
  output logic [TW-1:0]             CDB_T_idx,
  output logic [RW-1:0]             CDB_ROB_idx,
  output logic [VALUE_W-1:0]        CDB_value
);

  typedef struct packed {
    logic               valid;
    logic [TW-1:0]      T_idx;
    logic [RW-1:0]      ROB_idx;
    logic [VALUE_W-1:0] value;
  } cdb_packet_t;

  logic [NUM_FU-1:0] squash;
  logic [NUM_FU-1:0] eligible;
  logic [RW-1:0]     dt;
  logic [RW-1:0]     dt_m1;
  logic [RW-1:0]     rob_i;
  logic [RW-1:0]     d;

  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     next_ptr;
  logic [NUM_FU-1:0] rr_gnt;
  logic [PW-1:0]     rr_winner;
  logic [NUM_FU-1:0] win_gnt;
  logic [PW-1:0]     win_idx;
  logic              advance;

  cdb_packet_t       win_pkt;
  cdb_packet_t       cdb_q;

  // Younger than the branch means 1 <= d <= dt-1 with RW-bit wrap; dt=0 squashes every d>0.
  always_comb begin
    dt     = ROB_tail_idx - ROB_rollback_idx;
    dt_m1  = dt - 1'b1;
    rob_i  = '0;
    d      = '0;
    squash = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      rob_i     = fu_ROB_idx[i*RW +: RW];
      d         = rob_i - ROB_rollback_idx;
      squash[i] = ROB_rollback_en && (d != '0) && (d <= dt_m1);
    end
    eligible = fu_done & ~squash;
  end

  rr_arbiter #(
    .N (NUM_FU)
  ) u_rr_arbiter (
    .req    (eligible),
    .ptr    (rr_ptr),
    .gnt    (rr_gnt),
    .winner (rr_winner)
  );

  always_comb begin
    win_gnt = rr_gnt;
    win_idx = rr_winner;
    advance = |rr_gnt;
`ifdef MULT_PRIO_EN
    if (eligible[NUM_FU-1]) begin
      win_gnt             = '0;
      win_gnt[NUM_FU-1]   = 1'b1;
      win_idx             = PW'(NUM_FU - 1);
      advance             = 1'b0;
    end
`endif
    next_ptr = (win_idx == PW'(NUM_FU - 1)) ? '0 : win_idx + 1'b1;
  end

  always_comb begin
    win_pkt.valid   = |win_gnt;
    win_pkt.T_idx   = fu_T_idx[win_idx*TW +: TW];
    win_pkt.ROB_idx = fu_ROB_idx[win_idx*RW +: RW];
    win_pkt.value   = fu_result[win_idx*VALUE_W +: VALUE_W];
  end

  assign fu_grant = reset ? win_gnt : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      cdb_q  <= '0;
    end else begin
      if (advance)
        rr_ptr <= next_ptr;
      if (win_pkt.valid)
        cdb_q <= win_pkt;
      else
        cdb_q.valid <= 1'b0;
    end
  end

  assign CDB_valid   = cdb_q.valid;
  assign CDB_T_idx   = cdb_q.T_idx;
  assign CDB_ROB_idx = cdb_q.ROB_idx;
  assign CDB_value   = cdb_q.value;

endmodule
